// File: rtl/nibble_serial_add_ctrl_if.sv
// Handshake and operand/result bundle between a datapath and the nibble-serial adder controller.
// Latency: none (wires only).
// Backpressure: start is honoured only while ready is high; the controller never queues requests.
// Optional subtract select is present only when SUB_EN is defined.
interface nibble_serial_add_ctrl_if #(
  parameter int NIBBLES = 4
) ();
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
`ifdef SUB_EN
  logic         sub;
`endif
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
  logic         overflow;

  // Datapath side: issues requests, consumes results
  modport master (
`ifdef SUB_EN
    output sub,
`endif
    output start, a, b, c_in,
    input  ready, busy, done, result, c_out, overflow
  );

  // Controller side
  modport slave (
`ifdef SUB_EN
    input  sub,
`endif
    input  start, a, b, c_in,
    output ready, busy, done, result, c_out, overflow
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// W-bit add (optionally subtract with SUB_EN) using one 4-bit adder over NIBBLES passes, LS nibble first.
// Latency: start accepted at edge E0, done high in the cycle after edge E0+NIBBLES; one op per NIBBLES+2 cycles.
// Backpressure: start is accepted only in IDLE (ready=1); start while busy is dropped, not queued.

// Plain 4-bit ripple-carry adder; the only adder on the sum path.
module full_adder_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [4:0] carry;
  logic [3:0] sum;

  // Bit-by-bit ripple of the carry chain
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c_i;
    for (int i = 0; i < 4; i++) begin
      sum[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign s_o = sum;
  assign c_o = carry[4];
endmodule

module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  nibble_serial_add_ctrl_if.slave  bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     sa_q, sa_d;
  logic [W-1:0]     sb_q, sb_d;
  logic             cr_q, cr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     result_q, result_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       fa_s;
  logic             fa_c;
  logic [W-1:0]     acc_shift;

  full_adder_4bit u_fa (
    .a_i (sa_q[3:0]),
    .b_i (sb_q[3:0]),
    .c_i (cr_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // Accumulator after this pass: old contents move down a nibble, new sum nibble enters at the top
  always_comb begin
    acc_shift            = acc_q >> 4;
    acc_shift[W-1 -: 4]  = fa_s;
  end

  // Next-state and datapath control; every register holds unless its state acts on it
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cr_d     = cr_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d = bus.a;
`ifdef SUB_EN
          // Subtract as a + ~b + 1; c_in is irrelevant in that mode
          if (bus.sub) begin
            sb_d = ~bus.b;
            cr_d = 1'b1;
          end else begin
            sb_d = bus.b;
            cr_d = bus.c_in;
          end
`else
          sb_d = bus.b;
          cr_d = bus.c_in;
`endif
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 4;
        sb_d  = sb_q >> 4;
        acc_d = acc_shift;
        cr_d  = fa_c;
        cnt_d = cnt_q + CNT_W'(1);
        // Final pass sees the operand sign bits at SA[3]/SB[3]
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = acc_shift;
          c_out_d  = fa_c;
          ovf_d    = (sa_q[3] == sb_q[3]) && (fa_s[3] != sa_q[3]);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset (aborts any operation in flight)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      cr_q     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cr_q     <= cr_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl with NIBBLES=4; expected responses queued at issue time.
// Latency: checks done lands exactly NIBBLES+1 cycles after the start cycle.
// Backpressure: issues only when ready, and holds start through RUN to confirm it is dropped.
module tb_nibble_serial_add_ctrl;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    int           cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  int   dones;
  int   pushed;
  logic [W-1:0] last_res;
  exp_t exp_q[$];
  exp_t mon_e;

  nibble_serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: each done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!reset && bus.done === 1'b1) begin
      dones++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result",     32'(bus.result),   32'(mon_e.res));
        chk("c_out",      32'(bus.c_out),    32'(mon_e.co));
        chk("overflow",   32'(bus.overflow), 32'(mon_e.ov));
        chk("done_cycle", 32'(cyc),          32'(mon_e.cyc));
      end
    end
  end

  // Issue one request when ready; returns at the negedge inside the second RUN cycle
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                       input logic ts, input bit hold, input bit expect_done,
                       input logic [W-1:0] er, input logic eco, input logic eov);
    int n;
    exp_t e;
    n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_start", 32'(bus.ready), 32'd1);
    bus.a     = ta;
    bus.b     = tbv;
    bus.c_in  = tc;
`ifdef SUB_EN
    bus.sub   = ts;
`else
    if (ts) $display("note: subtract request issued without SUB_EN");
`endif
    bus.start = 1'b1;
    if (expect_done) begin
      e.res = er;
      e.co  = eco;
      e.ov  = eov;
      e.cyc = cyc + NIBBLES + 1;
      exp_q.push_back(e);
      pushed++;
    end
    @(negedge clk);
    if (!hold) begin
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.c_in  = 1'($urandom);
    end
    @(negedge clk);
    chk("busy_in_run",  32'(bus.busy),   32'd1);
    chk("ready_in_run", 32'(bus.ready),  32'd0);
    chk("held_result",  32'(bus.result), 32'(last_res));
    bus.start = 1'b0;
    if (expect_done) last_res = er;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.ready !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    dones     = 0;
    pushed    = 0;
    last_res  = '0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c_in  = 1'b0;
`ifdef SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready",    32'(bus.ready),    32'd1);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_done",     32'(bus.done),     32'd0);
    chk("rst_result",   32'(bus.result),   32'h0000);
    chk("rst_c_out",    32'(bus.c_out),    32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);

    // Plain add, no carries between nibbles
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
    wait_drain();
    // Carry-in ripples through every pass
    issue(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    wait_drain();
    // Signed overflow; start held high through RUN must not start a second op
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1);
    wait_drain();
    repeat (4) @(negedge clk);
    chk("single_done_count", 32'(dones), 32'(pushed));
    // Both negative: carry out and signed overflow together
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
    wait_drain();

    // Reset in the second RUN cycle aborts the op and clears the result
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready",  32'(bus.ready),  32'd1);
    chk("abort_busy",   32'(bus.busy),   32'd0);
    chk("abort_done",   32'(bus.done),   32'd0);
    chk("abort_result", 32'(bus.result), 32'h0000);
    last_res = '0;
    repeat (4) @(negedge clk);
    chk("abort_no_done", 32'(dones), 32'(pushed));
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    wait_drain();

`ifdef SUB_EN
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    wait_drain();
    issue(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    wait_drain();
`endif

    repeat (3) @(negedge clk);
    chk("final_done_count", 32'(dones), 32'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
